// File: rtl/fifo_eth_pack.sv
// ---------------------------------------------------------------------------
// fifo_eth_pack
//
// Reader side of the ADC capture path. On each frame start it drains
// channels 0..cnt-1 of the ADC FIFO bank and emits one Ethernet payload
// frame as a byte stream:
//   HDR0, HDR1, rx_len bytes per channel, then zero padding up to eth_tx_len.
// Frames are never truncated. If the header plus payload exceeds eth_tx_len,
// len_err_o is raised and stays set until the next frame start.
//
// Ports
//   clk_i            system clock (sys_clk)
//   rst_ni           asynchronous active-low reset
//   fs_i             frame start level; a rising edge seen in IDLE starts a frame
//   fd_o             frame done, held in DONE until fs_i drops
//   adc_rx_len_i     bytes taken from each FIFO per frame
//   eth_tx_len_i     minimum frame length in bytes, header included
//   adc_cnt_i        number of FIFOs to drain (clamped to NCH)
//   fifo_sel_o       index of the FIFO being drained
//   fifo_rd_en_o     pop strobe for the selected FIFO
//   fifo_rd_data_i   head word of the selected FIFO (first-word-fall-through)
//   fifo_empty_i     selected FIFO is empty
//   tx_data_o        output byte
//   tx_valid_o       tx_data_o is valid
//   tx_ready_i       downstream accepts the byte
//   tx_last_o        final byte of the frame
//   len_err_o        header plus payload exceeded eth_tx_len
//
// States
//   IDLE | waiting for a rising edge on fs_i
//   HEAD | emitting the two header bytes
//   DATA | popping rx_len bytes from each selected FIFO
//   PAD  | emitting zero bytes up to the frame length
//   DONE | fd_o high; waits for the last byte to drain and fs_i low
// ---------------------------------------------------------------------------
module fifo_eth_pack #(
  parameter int unsigned    NCH  = 8,
  parameter logic [7:0]     HDR0 = 8'h55,
  parameter logic [7:0]     HDR1 = 8'hAA
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fs_i,
  output logic        fd_o,
  input  logic [9:0]  adc_rx_len_i,
  input  logic [11:0] eth_tx_len_i,
  input  logic [7:0]  adc_cnt_i,
  output logic [2:0]  fifo_sel_o,
  output logic        fifo_rd_en_o,
  input  logic [7:0]  fifo_rd_data_i,
  input  logic        fifo_empty_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        tx_last_o,
  output logic        len_err_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAD = 3'd1,
    S_DATA = 3'd2,
    S_PAD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  // frame snapshot
  logic [9:0]  rx_len_q,    rx_len_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic [13:0] frame_len_q, frame_len_d;
  logic        len_err_q,   len_err_d;

  // counters
  logic [13:0] byte_cnt_q,  byte_cnt_d;
  logic [11:0] ch_byte_q,   ch_byte_d;
  logic [2:0]  ch_q,        ch_d;
  logic        hdr_sel_q,   hdr_sel_d;

  // one-deep output register
  logic [7:0]  tx_data_q,   tx_data_d;
  logic        tx_valid_q,  tx_valid_d;
  logic        tx_last_q,   tx_last_d;

  logic        fs_q;

  // frame-start geometry, evaluated from the live configuration bus
  logic [3:0]  cnt_in;
  logic [13:0] need_in;
  logic [13:0] tx_len_in;

  // control strobes
  logic        load;
  logic        frame_start;
  logic        byte_last;
  logic        ch_end;
  logic        ch_final;
  logic        rd_fire;
  logic        emit;
  logic [7:0]  emit_data;

  always_comb begin
    if (adc_cnt_i > 8'(NCH)) cnt_in = 4'(NCH);
    else                     cnt_in = adc_cnt_i[3:0];
  end

  // 8 channels x 1023 bytes + 2 header bytes fits in 14 bits
  assign need_in   = 14'd2 + ({10'd0, cnt_in} * {4'd0, adc_rx_len_i});
  assign tx_len_in = {2'b00, eth_tx_len_i};

  // the output register may take a new byte when empty or being drained
  assign load        = !tx_valid_q || tx_ready_i;
  assign frame_start = (state_q == S_IDLE) && fs_i && !fs_q;
  assign byte_last   = (byte_cnt_q + 14'd1) == frame_len_q;
  assign ch_end      = ch_byte_q == ({2'b00, rx_len_q} - 12'd1);
  assign ch_final    = {1'b0, ch_q} == (cnt_q - 4'd1);
  // pop and load happen in the same cycle from the fall-through head word
  assign rd_fire     = load && (state_q == S_DATA) && !fifo_empty_i;

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_HEAD;
      end
      S_HEAD: begin
        if (load && hdr_sel_q) begin
          if (byte_last)                              state_d = S_DONE;
          else if (cnt_q == 4'd0 || rx_len_q == 10'd0) state_d = S_PAD;
          else                                        state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rd_fire && ch_end && ch_final) begin
          if (byte_last) state_d = S_DONE;
          else           state_d = S_PAD;
        end
      end
      S_PAD: begin
        if (load && byte_last) state_d = S_DONE;
      end
      S_DONE: begin
        // the final byte must have left the output register
        if (load && !fs_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // output and datapath logic
  always_comb begin
    rx_len_d    = rx_len_q;
    cnt_d       = cnt_q;
    frame_len_d = frame_len_q;
    len_err_d   = len_err_q;
    byte_cnt_d  = byte_cnt_q;
    ch_byte_d   = ch_byte_q;
    ch_d        = ch_q;
    hdr_sel_d   = hdr_sel_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    tx_last_d   = tx_last_q;
    emit        = 1'b0;
    emit_data   = 8'h00;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          rx_len_d    = adc_rx_len_i;
          cnt_d       = cnt_in;
          frame_len_d = (need_in > tx_len_in) ? need_in : tx_len_in;
          len_err_d   = need_in > tx_len_in;
          byte_cnt_d  = 14'd0;
          ch_byte_d   = 12'd0;
          ch_d        = 3'd0;
          hdr_sel_d   = 1'b0;
        end
      end
      S_HEAD: begin
        if (load) begin
          emit      = 1'b1;
          emit_data = hdr_sel_q ? HDR1 : HDR0;
          hdr_sel_d = 1'b1;
        end
      end
      S_DATA: begin
        if (rd_fire) begin
          emit      = 1'b1;
          emit_data = fifo_rd_data_i;
          if (ch_end) begin
            ch_byte_d = 12'd0;
            // stay on the last channel so the select never exceeds NCH-1
            if (!ch_final) ch_d = ch_q + 3'd1;
          end else begin
            ch_byte_d = ch_byte_q + 12'd1;
          end
        end
      end
      S_PAD: begin
        if (load) begin
          emit      = 1'b1;
          emit_data = 8'h00;
        end
      end
      default: ;
    endcase

    if (load) begin
      tx_valid_d = emit;
      tx_last_d  = emit && byte_last;
      if (emit) begin
        tx_data_d  = emit_data;
        byte_cnt_d = byte_cnt_q + 14'd1;
      end
    end
  end

  // datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fs_q        <= 1'b0;
      rx_len_q    <= 10'd0;
      cnt_q       <= 4'd0;
      frame_len_q <= 14'd0;
      len_err_q   <= 1'b0;
      byte_cnt_q  <= 14'd0;
      ch_byte_q   <= 12'd0;
      ch_q        <= 3'd0;
      hdr_sel_q   <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
    end else begin
      fs_q        <= fs_i;
      rx_len_q    <= rx_len_d;
      cnt_q       <= cnt_d;
      frame_len_q <= frame_len_d;
      len_err_q   <= len_err_d;
      byte_cnt_q  <= byte_cnt_d;
      ch_byte_q   <= ch_byte_d;
      ch_q        <= ch_d;
      hdr_sel_q   <= hdr_sel_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
    end
  end

  assign fd_o         = (state_q == S_DONE);
  assign fifo_sel_o   = ch_q;
  assign fifo_rd_en_o = rd_fire;
  assign tx_data_o    = tx_data_q;
  assign tx_valid_o   = tx_valid_q;
  assign tx_last_o    = tx_last_q;
  assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_fifo_eth_pack.sv
// ---------------------------------------------------------------------------
// Bench for fifo_eth_pack. A behavioural FIFO bank feeds the DUT; the
// stimulus thread pushes each frame's expected bytes into a scoreboard and a
// negedge monitor pops and compares every accepted byte.
// ---------------------------------------------------------------------------
module tb_fifo_eth_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fs = 1'b0;
  logic        fd;
  logic [9:0]  adc_rx_len = 10'd0;
  logic [11:0] eth_tx_len = 12'd0;
  logic [7:0]  adc_cnt = 8'd0;
  logic [2:0]  fifo_sel;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'hEE;
  logic        fifo_empty = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_last;
  logic        len_err;

  always #5 clk = ~clk;

  fifo_eth_pack dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .fs_i           (fs),
    .fd_o           (fd),
    .adc_rx_len_i   (adc_rx_len),
    .eth_tx_len_i   (eth_tx_len),
    .adc_cnt_i      (adc_cnt),
    .fifo_sel_o     (fifo_sel),
    .fifo_rd_en_o   (fifo_rd_en),
    .fifo_rd_data_i (fifo_rd_data),
    .fifo_empty_i   (fifo_empty),
    .tx_data_o      (tx_data),
    .tx_valid_o     (tx_valid),
    .tx_ready_i     (tx_ready),
    .tx_last_o      (tx_last),
    .len_err_o      (len_err)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [8:0]  sb [$];
  logic [7:0]  mem [8][32];
  int          wp [8];
  int          rp [8];
  logic        bp_mode = 1'b0;
  logic        stall_mode = 1'b0;
  logic        stall = 1'b0;
  logic        do_pop = 1'b0;
  logic [2:0]  pop_sel = 3'd0;
  int          rd_cnt = 0;
  int          accepted = 0;
  int          cyc = 0;
  logic        hold_v = 1'b0;
  logic [7:0]  hold_data = 8'h00;
  logic        hold_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    logic [2:0] s;
    s = fifo_sel;
    fifo_empty = stall || (rp[s] >= wp[s]);
    if (rp[s] < wp[s] && rp[s] < 32) fifo_rd_data = mem[s][5'(rp[s])];
    else                             fifo_rd_data = 8'hEE;
  endtask

  // FIFO bank and downstream ready, updated just after each rising edge
  always @(posedge clk) begin
    #2;
    if (do_pop && rst_n) begin
      rp[pop_sel] = rp[pop_sel] + 1;
      rd_cnt++;
    end
    cyc++;
    tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    stall    = stall_mode && (fifo_sel == 3'd1) && ((cyc % 4) < 2);
    refresh();
  end

  // monitor: scoreboard compare, hold-stability and empty-read checks
  always @(negedge clk) begin
    logic [8:0] exp;
    do_pop  = fifo_rd_en && rst_n;
    pop_sel = fifo_sel;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (fifo_rd_en) check("rd_en_while_empty", 32'(fifo_empty), 32'd0);
      if (hold_v)
        check("stall_hold", 32'({tx_valid, tx_last, tx_data}), 32'({1'b1, hold_last, hold_data}));
      if (tx_valid && tx_ready) begin
        accepted++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_data);
        end else begin
          exp = sb.pop_front();
          check("tx_byte", 32'({tx_last, tx_data}), 32'(exp));
        end
      end
      hold_v    = tx_valid && !tx_ready;
      hold_data = tx_data;
      hold_last = tx_last;
    end
  end

  task automatic preload(input int nch, input int nb);
    for (int c = 0; c < 8; c++) begin
      wp[c] = 0;
      rp[c] = 0;
    end
    for (int c = 0; c < nch; c++) begin
      for (int i = 0; i < nb; i++) mem[c][i] = 8'((c + 1) * 16 + i);
      wp[c] = nb;
    end
    refresh();
  endtask

  // header, channel bytes, zero padding up to flen; tx_last on the final byte
  task automatic expect_frame(input int cnt, input int rx, input int flen);
    logic [7:0] q [$];
    q.push_back(8'h55);
    q.push_back(8'hAA);
    for (int c = 0; c < cnt; c++)
      for (int i = 0; i < rx; i++) q.push_back(8'((c + 1) * 16 + i));
    while (q.size() < flen) q.push_back(8'h00);
    for (int i = 0; i < q.size(); i++) sb.push_back({(i == q.size() - 1), q[i]});
  endtask

  task automatic start_frame(input logic [7:0] cnt, input logic [9:0] rx, input logic [11:0] tx);
    @(posedge clk);
    #1;
    adc_cnt    = cnt;
    adc_rx_len = rx;
    eth_tx_len = tx;
    rd_cnt     = 0;
    fs         = 1'b1;
  endtask

  task automatic wait_done(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (fd && sb.size() == 0 && !tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
    sb.delete();
  endtask

  task automatic end_frame(input string name);
    @(posedge clk);
    #1;
    fs = 1'b0;
    repeat (3) @(negedge clk);
    check(name, 32'(fd), 32'd0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ctl"}, 32'({tx_valid, tx_last, fd, len_err, fifo_rd_en}), 32'd0);
    check({name, "_data"}, 32'(tx_data), 32'd0);
    check({name, "_sel"}, 32'(fifo_sel), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    preload(0, 0);
    repeat (3) @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // nominal frame plus first-byte latency
    preload(2, 4);
    expect_frame(2, 4, 16);
    start_frame(8'd2, 10'd4, 12'd16);
    @(negedge clk);
    @(negedge clk);
    check("latency_early", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("latency_first", 32'({tx_valid, tx_data}), 32'h155);
    wait_done("nominal_done");
    check("nominal_len_err", 32'(len_err), 32'd0);
    check("nominal_rd_cnt", 32'(rd_cnt), 32'd8);

    // fs held high after DONE: no second frame
    base = accepted;
    repeat (10) @(negedge clk);
    check("hold_fd", 32'(fd), 32'd1);
    check("hold_no_frame", 32'({tx_valid, 1'b0} | 2'(accepted != base)), 32'd0);
    end_frame("nominal_fd_low");

    // second frame under backpressure and FIFO stalls on channel 1
    bp_mode    = 1'b1;
    stall_mode = 1'b1;
    preload(2, 4);
    expect_frame(2, 4, 16);
    start_frame(8'd2, 10'd4, 12'd16);
    wait_done("bp_done");
    check("bp_rd_cnt", 32'(rd_cnt), 32'd8);
    check("bp_len_err", 32'(len_err), 32'd0);
    end_frame("bp_fd_low");
    bp_mode    = 1'b0;
    stall_mode = 1'b0;

    // overflow: 2 + 3*10 = 32 > 20
    preload(3, 10);
    expect_frame(3, 10, 32);
    start_frame(8'd3, 10'd10, 12'd20);
    wait_done("ovf_done");
    check("ovf_len_err", 32'(len_err), 32'd1);
    check("ovf_rd_cnt", 32'(rd_cnt), 32'd30);
    end_frame("ovf_fd_low");
    check("ovf_len_err_sticky", 32'(len_err), 32'd1);

    // no channels: header plus three pad bytes, FIFOs untouched
    preload(2, 4);
    expect_frame(0, 4, 5);
    start_frame(8'd0, 10'd4, 12'd5);
    wait_done("zero_done");
    check("zero_rd_cnt", 32'(rd_cnt), 32'd0);
    check("zero_len_err", 32'(len_err), 32'd0);
    end_frame("zero_fd_low");

    // 12 channels clamp to 8: 2 + 8*1 = 10 > 0
    preload(8, 1);
    expect_frame(8, 1, 10);
    start_frame(8'd12, 10'd1, 12'd0);
    wait_done("clamp_done");
    check("clamp_rd_cnt", 32'(rd_cnt), 32'd8);
    check("clamp_len_err", 32'(len_err), 32'd1);
    end_frame("clamp_fd_low");

    // reset in the middle of DATA, then a clean frame
    preload(2, 4);
    expect_frame(2, 4, 16);
    base = accepted;
    start_frame(8'd2, 10'd4, 12'd16);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (accepted >= base + 5) break;
    end
    check("rst_reached_byte5", 32'(accepted >= base + 5), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    fs    = 1'b0;
    sb.delete();
    @(negedge clk);
    check_quiet("rst_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    preload(2, 4);
    expect_frame(2, 4, 16);
    start_frame(8'd2, 10'd4, 12'd16);
    wait_done("post_rst_done");
    check("post_rst_rd_cnt", 32'(rd_cnt), 32'd8);
    end_frame("post_rst_fd_low");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
